// File: rtl/stage_map_renderer.sv
// Stage tile-map renderer: walks the MAP_W x MAP_H tile map (or one tile) and emits
// one registered plot command per pixel. Optional macro TILE_BORDER_EN outlines non-floor tiles in black.
module stage_map_renderer #(
  parameter int TILE_SIZE = 8,
  parameter int MAP_W     = 11,
  parameter int MAP_H     = 11,
  parameter int ORIGIN_X  = 36,
  parameter int ORIGIN_Y  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       single,
  input  logic [6:0] tile_sel,
  output logic [6:0] map_addr,
  input  logic [3:0] map_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int SH      = $clog2(TILE_SIZE);
  localparam int PW      = (SH < 1) ? 1 : SH;
  localparam int N_TILES = MAP_W * MAP_H;
  localparam logic [PW-1:0] P_LAST = PW'(TILE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_single;
  logic [6:0]    r_index;
  logic [3:0]    r_col;
  logic [3:0]    r_row;
  logic [PW-1:0] r_px;
  logic [PW-1:0] r_py;
  logic [2:0]    r_fill;
  logic [6:0]    r_map_addr;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;

  logic [3:0]    w_sel_row;
  logic [3:0]    w_sel_col;
  logic          w_sel_valid;
  logic          w_idx_valid;
  logic          w_more;
  logic          w_last_px;
  logic [PW-1:0] w_px_n;
  logic [PW-1:0] w_py_n;
  logic [7:0]    w_base_x;
  logic [6:0]    w_base_y;
  logic [2:0]    w_fill_in;
  logic [2:0]    w_first_colour;
  logic [2:0]    w_draw_colour;

  // Row/column of tile_sel by comparison against row start offsets (no divider).
  always_comb begin
    w_sel_row = '0;
    w_sel_col = 4'(tile_sel);
    for (int r = 1; r < MAP_H; r++) begin
      if (tile_sel >= 7'(r * MAP_W)) begin
        w_sel_row = 4'(r);
        w_sel_col = 4'(tile_sel - 7'(r * MAP_W));
      end
    end
  end

  assign w_sel_valid = (tile_sel < 7'(N_TILES));
  assign w_idx_valid = (r_index < 7'(N_TILES));
  assign w_more      = !r_single && (r_index < 7'(N_TILES - 1));
  assign w_last_px   = (r_px == P_LAST) && (r_py == P_LAST);
  assign w_px_n      = (r_px == P_LAST) ? '0 : r_px + 1'b1;
  assign w_py_n      = (r_px == P_LAST) ? r_py + 1'b1 : r_py;
  assign w_base_x    = 8'(ORIGIN_X) + (8'(r_col) << SH);
  assign w_base_y    = 7'(ORIGIN_Y) + (7'(r_row) << SH);

  always_comb begin
    case (map_data)
      4'd0:    w_fill_in = 3'b010;
      4'd1:    w_fill_in = 3'b111;
      4'd2:    w_fill_in = 3'b110;
      4'd3:    w_fill_in = 3'b100;
      4'd4:    w_fill_in = 3'b101;
      default: w_fill_in = 3'b001;
    endcase
  end

`ifdef TILE_BORDER_EN
  logic [3:0] r_code;

  // Pixel (0,0) is always on the outline, so the first colour only depends on the code.
  assign w_first_colour = (map_data != 4'd0) ? 3'b000 : w_fill_in;
  assign w_draw_colour  = ((r_code != 4'd0) &&
                           (w_px_n == '0 || w_px_n == P_LAST ||
                            w_py_n == '0 || w_py_n == P_LAST)) ? 3'b000 : r_fill;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_code <= '0;
    end else if (r_state == S_LATCH) begin
      r_code <= map_data;
    end
  end
`else
  assign w_first_colour = w_fill_in;
  assign w_draw_colour  = r_fill;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An out-of-range single tile uses its FETCH slot as the range check and skips to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = w_idx_valid ? S_LATCH : S_DONE;
      S_LATCH: w_next = S_DRAW;
      S_DRAW:  if (w_last_px) w_next = w_more ? S_FETCH : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pixel outputs are loaded one edge ahead so they line up with the DRAW cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_single   <= 1'b0;
      r_index    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_fill     <= '0;
      r_map_addr <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          if (start) begin
            r_single <= single;
            if (single) begin
              r_index <= tile_sel;
              r_col   <= w_sel_col;
              r_row   <= w_sel_row;
              if (w_sel_valid) r_map_addr <= tile_sel;
            end else begin
              r_index    <= '0;
              r_col      <= '0;
              r_row      <= '0;
              r_map_addr <= '0;
            end
          end
        end
        S_LATCH: begin
          r_fill   <= w_fill_in;
          r_px     <= '0;
          r_py     <= '0;
          r_plot   <= 1'b1;
          r_x      <= w_base_x;
          r_y      <= w_base_y;
          r_colour <= w_first_colour;
        end
        S_DRAW: begin
          if (w_last_px) begin
            r_plot <= 1'b0;
            if (w_more) begin
              r_index    <= r_index + 7'd1;
              r_map_addr <= r_index + 7'd1;
              if (r_col == 4'(MAP_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + 4'd1;
              end else begin
                r_col <= r_col + 4'd1;
              end
            end
          end else begin
            r_px     <= w_px_n;
            r_py     <= w_py_n;
            r_x      <= w_base_x + 8'(w_px_n);
            r_y      <= w_base_y + 7'(w_py_n);
            r_colour <= w_draw_colour;
          end
        end
        default: r_plot <= 1'b0;
      endcase
    end
  end

  assign map_addr   = r_map_addr;
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour_out = r_colour;
  assign plot       = r_plot;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_stage_map_renderer.sv
// Bench for stage_map_renderer: expected pixels and done cycles are queued by the
// drivers and consumed by a negedge monitor. Honours TILE_BORDER_EN in its colour model.
module tb_stage_map_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       single;
  logic [6:0] tile_sel;
  logic [6:0] map_addr;
  logic [3:0] map_data;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  logic [3:0]  mem [0:127];
  logic [17:0] exp_q[$];
  int          exp_done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_plot  = 0;
  int n_black = 0;
  int n_done  = 0;
  logic [7:0] first_x, last_x;
  logic [6:0] first_y, last_y;

  stage_map_renderer dut (
    .clock(clock), .reset(reset), .start(start), .single(single),
    .tile_sel(tile_sel), .map_addr(map_addr), .map_data(map_data),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  // clock / memory model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    map_data <= mem[map_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] mdl_colour(input logic [3:0] code, input int px, input int py);
    logic [2:0] c;
    case (code)
      4'd0:    c = 3'b010;
      4'd1:    c = 3'b111;
      4'd2:    c = 3'b110;
      4'd3:    c = 3'b100;
      4'd4:    c = 3'b101;
      default: c = 3'b001;
    endcase
`ifdef TILE_BORDER_EN
    if (code != 4'd0 && (px == 0 || px == 7 || py == 0 || py == 7)) c = 3'b000;
`endif
    return c;
  endfunction

  task automatic push_tile(input int idx, input logic [3:0] code);
    int row, col;
    row = idx / 11;
    col = idx % 11;
    for (int py = 0; py < 8; py++)
      for (int px = 0; px < 8; px++)
        exp_q.push_back({8'(36 + col * 8 + px), 7'(16 + row * 8 + py), mdl_colour(code, px, py)});
  endtask

  // driver tasks
  task automatic issue(input logic s, input logic [6:0] sel, input int len);
    @(posedge clock); #1;
    start    = 1'b1;
    single   = s;
    tile_sel = sel;
    n_plot   = 0;
    n_black  = 0;
    exp_done_q.push_back(cyc + len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if (n_done == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (plot === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pixel: unexpected plot at x=%0d y=%0d c=%0d", x_out, y_out, colour_out);
        end else begin
          check("pixel{x,y,c}", {14'd0, x_out, y_out, colour_out}, {14'd0, exp_q.pop_front()});
        end
        if (n_plot == 0) begin
          first_x = x_out;
          first_y = y_out;
        end
        last_x = x_out;
        last_y = y_out;
        if (colour_out == 3'b000) n_black++;
        n_plot++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (exp_done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done: unexpected done pulse at cycle %0d", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $finish;
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    single   = 1'b0;
    tile_sel = '0;
    for (int i = 0; i < 128; i++) mem[i] = 4'd0;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour_out, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_map_addr", map_addr, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // single tile 60, soft block
    mem[60] = 4'd2;
    push_tile(60, 4'd2);
    issue(1'b1, 7'd60, 67);
    @(negedge clock);
    check("single60_map_addr", map_addr, 60);
    check("single60_busy", busy, 1);
    wait_done(100, "single60");
    check("single60_busy_in_done", busy, 1);
    check("single60_plots", n_plot, 64);
    check("single60_first_x", first_x, 76);
    check("single60_first_y", first_y, 56);
    check("single60_last_x", last_x, 83);
    check("single60_last_y", last_y, 63);
    check("single60_leftover", exp_q.size(), 0);
    @(negedge clock);
    check("single60_idle_busy", busy, 0);

    // out-of-range single tile
    issue(1'b1, 7'd121, 2);
    wait_done(10, "single121");
    check("single121_plots", n_plot, 0);

    // outline feature: wall tile then floor tile
    mem[0] = 4'd1;
    push_tile(0, 4'd1);
    issue(1'b1, 7'd0, 67);
    wait_done(100, "single0_wall");
`ifdef TILE_BORDER_EN
    check("wall_black_pixels", n_black, 28);
`else
    check("wall_black_pixels", n_black, 0);
`endif
    check("wall_plots", n_plot, 64);
    mem[1] = 4'd0;
    push_tile(1, 4'd0);
    issue(1'b1, 7'd1, 67);
    wait_done(100, "single1_floor");
    check("floor_black_pixels", n_black, 0);
    check("floor_plots", n_plot, 64);

    // full redraw, all hard walls
    for (int i = 0; i < 121; i++) begin
      mem[i] = 4'd1;
      push_tile(i, 4'd1);
    end
    issue(1'b0, 7'd0, 7987);
    wait_done(8100, "full_walls");
    check("full_plots", n_plot, 7744);
    check("full_first_x", first_x, 36);
    check("full_first_y", first_y, 16);
    check("full_last_x", last_x, 123);
    check("full_last_y", last_y, 103);
    check("full_leftover", exp_q.size(), 0);

    // full redraw with mixed codes and an ignored start
    mem[0] = 4'd3;
    mem[1] = 4'd4;
    mem[2] = 4'd9;
    for (int i = 0; i < 121; i++) push_tile(i, mem[i]);
    issue(1'b0, 7'd0, 7987);
    repeat (100) @(posedge clock);
    #1;
    start    = 1'b1;
    single   = 1'b1;
    tile_sel = 7'd5;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(8100, "full_mixed");
    check("mixed_plots", n_plot, 7744);
    check("mixed_leftover", exp_q.size(), 0);
    @(negedge clock);
    check("mixed_idle_busy", busy, 0);

    // reset in the middle of tile 5
    for (int i = 0; i < 121; i++) push_tile(i, mem[i]);
    issue(1'b0, 7'd0, 7987);
    repeat (340) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    begin
      int d0;
      d0 = n_done;
      @(negedge clock);
      check("abort_plot", plot, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_x", x_out, 0);
      check("abort_y", y_out, 0);
      check("abort_colour", colour_out, 0);
      check("abort_map_addr", map_addr, 0);
      repeat (200) @(negedge clock);
      check("abort_no_done", n_done, d0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
